// File: rtl/sum_pkt_pkg.sv
// Shared types and helpers for the sum-it packet driver.
// Holds the driver state enum, a default-sized packet record and the
// width helper for the done-wait timeout counter.
package sum_pkt_pkg;

  localparam int unsigned PKT_W          = 16;
  localparam int unsigned PKT_SUM_W      = 16;
  localparam int unsigned PKT_MAX_VALUES = 5;
  localparam int unsigned PKT_CNT_W      = $clog2(PKT_MAX_VALUES + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_REPORT    = 2'd3
  } sum_pkt_state_e;

  // Packet as offered by a source; sized to the driver's default parameters.
  typedef struct packed {
    logic [PKT_MAX_VALUES-1:0][PKT_W-1:0] values;
    logic [PKT_CNT_W-1:0]                 count;
  } sum_pkt_t;

  // The timeout counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned tmo_cnt_w(input int unsigned timeout);
    int unsigned w;
    w = (timeout < 1) ? 1 : $clog2(timeout + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sum_pkt_checker.sv
// Expected-sum accumulator for the packet driver.
// Clears when a packet is accepted and adds every operand as it is sent;
// operands are zero-extended to SUM_W and the sum wraps modulo 2^SUM_W.
module sum_pkt_checker
  import sum_pkt_pkg::*;
#(
  parameter int W     = 16,
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [W-1:0]     operand,
  output logic [SUM_W-1:0] expected
);

  // Running sum of the operands presented on the accumulator input.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      expected <= '0;
    end else if (add_en) begin
      expected <= expected + SUM_W'(operand);
    end
  end

endmodule

// File: rtl/sum_pkt_driver.sv
// Packet driver for the sum-it accumulator.
// Accepts a packet over valid/ready, streams its operands on inA with an
// active-low go_l on the first one, then waits (bounded) for done and
// reports the captured result for one cycle.
// Build option: define SUM_PKT_DRIVER_CHECK_EN to build the expected-sum
// checker; without it res_ok is 1 on every done completion.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a packet
// ST_SEND      | presenting operand idx on inA (go_l low for idx 0)
// ST_WAIT_DONE | operands sent, waiting for done or timeout
// ST_REPORT    | res_valid high for this single cycle
module sum_pkt_driver
  import sum_pkt_pkg::*;
#(
  parameter int W          = 16,
  parameter int SUM_W      = 16,
  parameter int MAX_VALUES = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pkt_valid,
  output logic                               pkt_ready,
  input  logic [MAX_VALUES-1:0][W-1:0]       pkt_values,
  input  logic [$clog2(MAX_VALUES+1)-1:0]    pkt_count,
  output logic [W-1:0]                       inA,
  output logic                               go_l,
  input  logic                               done,
  input  logic [SUM_W-1:0]                   outResult,
  output logic                               res_valid,
  output logic [SUM_W-1:0]                   res_sum,
  output logic                               res_ok,
  output logic                               res_timeout
);

  localparam int CW = $clog2(MAX_VALUES + 1);
  localparam int IW = (MAX_VALUES > 1) ? $clog2(MAX_VALUES) : 1;
  localparam int TW = tmo_cnt_w(TIMEOUT);

  sum_pkt_state_e                state, state_nxt;
  logic [MAX_VALUES-1:0][W-1:0]  values_q;
  logic [CW-1:0]                 cnt_q;
  logic [CW-1:0]                 idx;
  logic [CW-1:0]                 idx_nxt;
  logic [CW-1:0]                 cnt_clamp;
  logic [TW-1:0]                 tmo;
  logic                          accept;
  logic                          last_op;
  logic                          tmo_hit;
  logic                          match;

  assign accept    = pkt_valid && pkt_ready;
  assign cnt_clamp = (pkt_count > CW'(MAX_VALUES)) ? CW'(MAX_VALUES) : pkt_count;
  assign idx_nxt   = idx + CW'(1);
  assign last_op   = (idx == (cnt_q - CW'(1)));
  assign tmo_hit   = (tmo == TW'(TIMEOUT));

`ifdef SUM_PKT_DRIVER_CHECK_EN
  logic [SUM_W-1:0] expected;

  sum_pkt_checker #(
    .W     (W),
    .SUM_W (SUM_W)
  ) u_checker (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .add_en   (state == ST_SEND),
    .operand  (inA),
    .expected (expected)
  );

  assign match = (outResult == expected);
`else
  assign match = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; done only matters while waiting for it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (cnt_clamp == '0) ? ST_REPORT : ST_SEND;
        end
      end
      ST_SEND: begin
        if (last_op) begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done || tmo_hit) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake and strobe outputs, forced low while reset is asserted.
  always_comb begin
    pkt_ready = 1'b0;
    res_valid = 1'b0;
    if (!reset) begin
      pkt_ready = (state == ST_IDLE);
      res_valid = (state == ST_REPORT);
    end
  end

  // Datapath: packet capture, operand streaming, timeout and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      values_q    <= '0;
      cnt_q       <= '0;
      idx         <= '0;
      tmo         <= '0;
      inA         <= '0;
      go_l        <= 1'b1;
      res_sum     <= '0;
      res_ok      <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            values_q <= pkt_values;
            cnt_q    <= cnt_clamp;
            idx      <= '0;
            if (cnt_clamp == '0) begin
              // Empty packet: report a trivially correct zero sum.
              res_sum     <= '0;
              res_ok      <= 1'b1;
              res_timeout <= 1'b0;
            end else begin
              // Operand 0 comes straight from the port so it appears
              // right after the accept edge.
              inA  <= pkt_values[0];
              go_l <= 1'b0;
            end
          end
        end
        ST_SEND: begin
          go_l <= 1'b1;
          if (last_op) begin
            inA <= '0;
            tmo <= '0;
          end else begin
            idx <= idx_nxt;
            inA <= values_q[idx_nxt[IW-1:0]];
          end
        end
        ST_WAIT_DONE: begin
          if (done) begin
            res_sum     <= outResult;
            res_ok      <= match;
            res_timeout <= 1'b0;
          end else if (tmo_hit) begin
            res_sum     <= '0;
            res_ok      <= 1'b0;
            res_timeout <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        ST_REPORT: begin
          // Results hold until the next report.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_pkt_driver.sv
// Self-checking bench for sum_pkt_driver: directed packets from the test
// plan followed by randomized packets, with a result scoreboard.
module tb_sum_pkt_driver;
  import sum_pkt_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int MAXV    = 5;

  localparam int M_OK  = 0;
  localparam int M_BAD = 1;
  localparam int M_TMO = 2;
  localparam int M_RST = 3;

  logic                  clk;
  logic                  reset;
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [MAXV-1:0][15:0] pkt_values;
  logic [2:0]            pkt_count;
  logic [15:0]           inA;
  logic                  go_l;
  logic                  done;
  logic [15:0]           outResult;
  logic                  res_valid;
  logic [15:0]           res_sum;
  logic                  res_ok;
  logic                  res_timeout;

  typedef struct {
    logic [15:0] sum;
    logic        ok;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sum_pkt_driver #(
    .W          (16),
    .SUM_W      (16),
    .MAX_VALUES (MAXV),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_values  (pkt_values),
    .pkt_count   (pkt_count),
    .inA         (inA),
    .go_l        (go_l),
    .done        (done),
    .outResult   (outResult),
    .res_valid   (res_valid),
    .res_sum     (res_sum),
    .res_ok      (res_ok),
    .res_timeout (res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_sum", 32'(res_sum), 32'(e.sum));
        chk("res_ok", 32'(res_ok), 32'(e.ok));
        chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inA"}, 32'(inA), 32'd0);
    chk({tag, "_go_l"}, 32'(go_l), 32'd1);
    chk({tag, "_pkt_ready"}, 32'(pkt_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_sum"}, 32'(res_sum), 32'd0);
    chk({tag, "_res_ok"}, 32'(res_ok), 32'd0);
    chk({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
  endtask

  // Offer one packet and act as the accumulator for it.
  task automatic run_pkt(input sum_pkt_t p, input int mode, input int d, input bit done_in_send);
    int          n;
    int unsigned s;
    int          cyc;
    exp_t        e;
    logic [15:0] sum16;

    n = (int'(p.count) > MAXV) ? MAXV : int'(p.count);
    s = 0;
    for (int k = 0; k < n; k++) s += p.values[k];
    sum16 = s[15:0];

    cyc = 0;
    @(negedge clk);
    while (pkt_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("pkt_ready_wait", 32'(pkt_ready), 32'd1);

    pkt_valid  = 1'b1;
    pkt_values = p.values;
    pkt_count  = p.count;

    if (mode != M_RST) begin
      if (n == 0) begin
        e.sum = 16'd0; e.ok = 1'b1; e.tmo = 1'b0;
      end else if (mode == M_TMO) begin
        e.sum = 16'd0; e.ok = 1'b0; e.tmo = 1'b1;
      end else if (mode == M_BAD) begin
        e.sum = sum16 - 16'd1;
`ifdef SUM_PKT_DRIVER_CHECK_EN
        e.ok  = 1'b0;
`else
        e.ok  = 1'b1;
`endif
        e.tmo = 1'b0;
      end else begin
        e.sum = sum16; e.ok = 1'b1; e.tmo = 1'b0;
      end
      sb.push_back(e);
    end

    @(posedge clk);

    if (n == 0) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      chk("empty_res_valid", 32'(res_valid), 32'd1);
      chk("empty_inA", 32'(inA), 32'd0);
      chk("empty_go_l", 32'(go_l), 32'd1);
      @(negedge clk);
      chk("empty_res_valid_drop", 32'(res_valid), 32'd0);
      chk("empty_ready_back", 32'(pkt_ready), 32'd1);
      return;
    end

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      chk("send_inA", 32'(inA), 32'(p.values[k]));
      chk("send_go_l", 32'(go_l), (k == 0) ? 32'd0 : 32'd1);
      done      = done_in_send;
      outResult = 16'($urandom);
      if (mode == M_RST && k == 1) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        done  = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("midreset_no_res_valid", 32'(res_valid), 32'd0);
        end
        return;
      end
    end

    @(negedge clk);
    done = 1'b0;
    chk("after_send_inA", 32'(inA), 32'd0);
    chk("after_send_go_l", 32'(go_l), 32'd1);

    if (mode == M_TMO) begin
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("timeout_latency", 32'(cyc), 32'(TIMEOUT + 1));
    end else begin
      repeat (d) begin
        @(negedge clk);
        chk("wait_no_res_valid", 32'(res_valid), 32'd0);
      end
      done      = 1'b1;
      outResult = (mode == M_OK) ? sum16 : sum16 - 16'd1;
      @(negedge clk);
      done      = 1'b0;
      outResult = 16'($urandom);
      chk("done_latency", 32'(res_valid), 32'd1);
    end

    @(negedge clk);
    chk("res_valid_one_cycle", 32'(res_valid), 32'd0);
    chk("ready_after_report", 32'(pkt_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=stalled required=finished");
    $fatal(1, "bench stalled");
  end

  initial begin
    sum_pkt_t p;
    int       r;
    int       mode;

    reset      = 1'b1;
    pkt_valid  = 1'b0;
    pkt_values = '0;
    pkt_count  = '0;
    done       = 1'b0;
    outResult  = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(pkt_ready), 32'd1);

    p.values = '0;
    p.values[0] = 16'd55;
    p.values[1] = 16'd22;
    p.values[2] = 16'd11;
    p.count = 3'd3;
    run_pkt(p, M_OK, 1, 1'b0);
    run_pkt(p, M_BAD, 1, 1'b0);

    p.values = '0;
    p.values[0] = 16'hFFFF;
    p.values[1] = 16'h0002;
    p.count = 3'd2;
    run_pkt(p, M_OK, 0, 1'b0);

    p.count = 3'd0;
    run_pkt(p, M_OK, 0, 1'b0);

    for (int k = 0; k < MAXV; k++) p.values[k] = 16'(100 * (k + 1));
    p.count = 3'd7;
    run_pkt(p, M_OK, 2, 1'b0);

    p.count = 3'd3;
    run_pkt(p, M_TMO, 0, 1'b1);

    run_pkt(p, M_RST, 0, 1'b0);

    p.values = '0;
    p.values[0] = 16'd1;
    p.values[1] = 16'd2;
    p.count = 3'd2;
    run_pkt(p, M_OK, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      p.count = 3'($urandom_range(0, 7));
      for (int k = 0; k < MAXV; k++) begin
        if ($urandom_range(0, 3) == 0) p.values[k] = 16'hFFFF - 16'($urandom_range(0, 15));
        else p.values[k] = 16'($urandom);
      end
      r = $urandom_range(0, 9);
      mode = (r < 6) ? M_OK : (r < 9) ? M_BAD : M_TMO;
      run_pkt(p, mode, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
